// File: rtl/dff_reg_arbiter.sv
// Round-robin write arbiter for a shared dff-built register: grant, strobe, settle, readback check.
// Build option: DFF_ARB_READBACK_EN enables the reg_Q compare with bounded rewrite retries.
module dff_reg_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 2
) (
  input  logic                   C,
  input  logic                   nR,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]       reg_Q,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       reg_D,
  output logic                   reg_we,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SETTLE, S_CHECK} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, win_q, win_d, pick;
  logic [IW:0]        idx;
  logic               found, fin;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, pick_oh;
  logic [WIDTH-1:0]   data_q, data_d, sel;
  logic               we_q, we_d, busy_q, busy_d;
`ifdef DFF_ARB_READBACK_EN
  logic [2:0]         retry_q, retry_d;
  logic               err_q, err_d;
`else
  logic               unused_ok;
  assign unused_ok = ^{reg_Q, 3'(MAX_RETRY)};
`endif

  // First set request above the pointer, wrapping; pointer starts at N_REQ-1 so req[0] leads.
  always_comb begin
    pick    = '0;
    found   = 1'b0;
    idx     = '0;
    sel     = '0;
    pick_oh = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        sel        = wdata[i*WIDTH +: WIDTH];
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = '0;
    fin     = 1'b0;
`ifdef DFF_ARB_READBACK_EN
    retry_d = retry_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          data_d  = sel;
          gnt_d   = pick_oh;
          we_d    = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = 4'(SETTLE_CYC);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q <= 4'd1) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
`ifdef DFF_ARB_READBACK_EN
        if (reg_Q != data_q && retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          we_d    = 1'b1;
          state_d = S_GRANT;
        end else begin
          err_d = (reg_Q != data_q);
          fin   = 1'b1;
        end
`else
        fin = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      done_d  = gnt_q;
      ptr_d   = win_q;
      gnt_d   = '0;
      state_d = S_IDLE;
`ifdef DFF_ARB_READBACK_EN
      retry_d = '0;
`endif
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ-1);
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifdef DFF_ARB_READBACK_EN
      retry_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef DFF_ARB_READBACK_EN
      retry_q <= retry_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign reg_D  = data_q;
  assign reg_we = we_q;
  assign done   = done_q;
  assign busy   = busy_q;
`ifdef DFF_ARB_READBACK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Randomized bench for dff_reg_arbiter against a transaction-level schedule model.
module tb_dff_reg_arbiter;
  localparam int N = 4, W = 8, S = 2, MR = 2, NCYC = 4000;
`ifdef DFF_ARB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic C = 1'b0, nR;
  logic [N-1:0] req, gnt, done;
  logic [N*W-1:0] wdata;
  logic [W-1:0] reg_Q, reg_D, bank_q, stuck_v;
  logic reg_we, err, busy;
  bit stuck;

  dff_reg_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut (
    .C(C), .nR(nR), .req(req), .wdata(wdata), .reg_Q(reg_Q), .gnt(gnt),
    .reg_D(reg_D), .reg_we(reg_we), .done(done), .err(err), .busy(busy));

  always #5 C = ~C;
  // Behavioural dff bank: captures D while the strobe is high, unless forced stuck.
  always @(posedge C) if (reg_we) bank_q <= reg_D;
  assign reg_Q = stuck ? stuck_v : bank_q;

  // Expected output per cycle index (cycle n = interval after rising edge n).
  logic [N-1:0] e_gnt [NCYC];
  logic [N-1:0] e_done[NCYC];
  bit e_we[NCYC], e_err[NCYC], e_busy[NCYC], d_set[NCYC];
  logic [W-1:0] d_val[NCYC];
  logic [W-1:0] rD;
  int n_cmp = 0, n_bad = 0, n = 0, ptr, next_arb;
  int we_cnt, done_seen;
  bit count_we, track2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic clear_from(input int s);
    for (int c = s; c < NCYC; c++) begin
      e_gnt[c] = '0; e_done[c] = '0; e_we[c] = 0; e_err[c] = 0; e_busy[c] = 0;
      d_set[c] = 0; d_val[c] = '0;
    end
  endtask

  task automatic check_cycle();
    if (n < NCYC) begin
      if (d_set[n]) rD = d_val[n];
      chk("gnt", gnt, e_gnt[n]);
      chk("reg_we", reg_we, e_we[n]);
      chk("done", done, e_done[n]);
      chk("err", err, e_err[n]);
      chk("busy", busy, e_busy[n]);
      chk("reg_D", reg_D, rD);
    end
    if (count_we && reg_we) we_cnt++;
    if (track2 && done[2] && done_seen < 0) done_seen = n;
  endtask

  // One transaction won at edge t: attempts of GRANT + S settle + CHECK, then a done cycle.
  task automatic schedule(input int t, input int w, input logic [W-1:0] d);
    bit bad;
    int att, len;
    logic [N-1:0] oh;
    bad = stuck && RB && (d !== stuck_v);
    att = bad ? 1 + MR : 1;
    len = att * (S + 2);
    oh  = N'(1) << w;
    if (t + len < NCYC) begin
      for (int c = t; c < t + len; c++) begin e_gnt[c] = oh; e_busy[c] = 1; end
      for (int a = 0; a < att; a++) e_we[t + a*(S+2)] = 1;
      d_set[t] = 1; d_val[t] = d;
      e_done[t+len] = oh;
      e_err[t+len]  = bad;
    end
    next_arb = t + len + 1;
    ptr = w;
  endtask

  task automatic arbitrate(input int e);
    int i;
    if (nR && e >= next_arb && |req) begin
      for (int k = 1; k <= N; k++) begin
        i = (ptr + k) % N;
        if (req[i]) begin
          schedule(e, i, wdata[i*W +: W]);
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    nR = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_D", reg_D, 0);
    clear_from(n + 1);
    rD = '0; ptr = N - 1; next_arb = 0;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] wd, input bit lo);
    @(posedge C); n++;
    @(negedge C);
    check_cycle();
    req = r; wdata = wd;
    if (lo && nR) do_reset();
    else if (!lo) nR = 1'b1;
    arbitrate(n + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && n + 1 < next_arb; i++) step('0, wdata, 0);
    step('0, wdata, 0);
  endtask

  initial begin
    int hold;
    logic [N*W-1:0] wd;
    clear_from(0);
    nR = 1'b1; req = '1; wdata = '0; stuck = 0; stuck_v = '0; bank_q = '0;
    rD = '0; ptr = N - 1; next_arb = 0; we_cnt = 0; count_we = 0; track2 = 0; done_seen = -1;
    #2 do_reset();
    for (int i = 0; i < 3; i++) step('1, 32'h11223344, 1);
    // Release with all four requesting: first grant to req[0], then rotation.
    step('1, 32'h11223344, 0);
    step('1, 32'h55667788, 0);
    chk("first_gnt", gnt, 4'b0001);
    for (int i = 0; i < 40; i++) step('1, $urandom(), 0);
    drain();

    // Single write of A5 by requester 2; done five cycles after req.
    track2 = 1;
    step(4'b0100, 32'h00A50000, 0);
    hold = n;
    drain();
    chk("req2done", done_seen - hold, 5);
    track2 = 0;

    // Random traffic, bank follows D, occasional resets.
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      bit lo;
      lo = 0;
      if (hold > 0) begin hold--; lo = 1; end
      else if ($urandom_range(0, 79) == 0) begin hold = $urandom_range(0, 2); lo = 1; end
      step(N'($urandom() & $urandom()), $urandom(), lo);
    end
    drain();

    // Bank stuck at 00: write of 3C exercises the retry/err path.
    stuck = 1; stuck_v = 8'h00;
    count_we = 1; we_cnt = 0;
    step(4'b0001, 32'h0000003C, 0);
    drain();
    count_we = 0;
    chk("we_pulses", we_cnt, RB ? 1 + MR : 1);
    for (int i = 0; i < 300; i++) begin
      wd = $urandom();
      if ($urandom_range(0, 2) == 0) wd[8*$urandom_range(0, 3) +: 8] = 8'h00;
      step(N'($urandom()), wd, 0);
    end
    drain();
    stuck = 0;

    // Reset landing in SETTLE: no done, next grant to lowest pending.
    step(4'b0011, $urandom(), 0);
    step(4'b0011, $urandom(), 0);
    step(4'b1010, $urandom(), 1);
    step(4'b1010, $urandom(), 0);
    step(4'b1010, $urandom(), 0);
    chk("post_rst_gnt", gnt, 4'b0010);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
